counter_share_ctrl: RTL

//   Shares one external 4-bit synchronous up-counter between N_REQ requesters.

---
 rtl/counter_share_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: round-robin owner of one shared external up-counter.
// Clears the counter, enables it up to the owner's terminal count, then pulses done.
module counter_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] term,
    input  logic [N_REQ-1:0]    hold,
    input  logic [CW-1:0]       cnt_val,
    output logic                cnt_en,
    output logic                cnt_clr,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                busy
);
    // state | meaning
    // IDLE  | no owner; arbitrate among req every cycle
    // CLR   | one-cycle synchronous clear of the shared counter
    // RUN   | count until cnt_val equals term_lat; hold pauses, dropped req aborts
    // DONE  | one-cycle done pulse to the owner, then release
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [CW-1:0]    term_lat, term_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [PW-1:0]    rr_ptr, rr_nxt;
    logic [PW-1:0]    owner_inc;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             owner_req;
    logic             owner_hold;
    logic             at_term;

    // Masking with the latched grant keeps non-owners' req/hold out of the decision.
    assign owner_req  = |(req & grant);
    assign owner_hold = |(hold & grant);
    assign at_term    = (cnt_val == term_lat);
    assign owner_inc  = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
    assign busy       = (state != IDLE);

    always_comb begin : arb_search
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        term_nxt  = term_lat;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        done      = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt          = CLR;
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    term_nxt           = term[int'(win_idx)*CW +: CW];
                    owner_nxt          = win_idx;
                end
            end
            CLR: begin
                cnt_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                // Abort outranks reaching the terminal count in the same cycle.
                if (!owner_req) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    rr_nxt    = owner_inc;
                end else if (at_term) begin
                    state_nxt = DONE;
                end else begin
                    cnt_en = ~owner_hold;
                end
            end
            DONE: begin
                done      = grant;
                state_nxt = IDLE;
                grant_nxt = '0;
                rr_nxt    = owner_inc;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            term_lat <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            term_lat <= term_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

endmodule
